// File: rtl/nios_mult_seq_unit.sv
// nios_mult_seq_unit: iterative slice multiplier with signed correction and valid/ready handshake
module nios_mult_seq_unit #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_W-1:0]     in_a,
  input  logic [DATA_W-1:0]     in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [2*DATA_W-1:0]   out_product
);
  localparam int N  = DATA_W / SLICE_W;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int MW = 2 * SLICE_W;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  typedef enum logic [1:0] {IDLE, MAC, FIX, DONE} state_t;
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]          op_q, op_d;
  logic [IW-1:0]       i_q, i_d, j_q, j_d;
  logic [IW:0]         sh_q, sh_d;
  logic [MW-1:0]       prod_q, prod_d;
  logic                pv_q, pv_d, last_q, last_d;
  logic [PW-1:0]       acc_q, acc_d, prodo_q, prodo_d, fix;
  assign in_ready    = (state_q == IDLE) && !reset;
  assign out_valid   = state_q == DONE;
  assign out_result  = res_q;
  assign out_product = prodo_q;
  // Two's-complement correction of the unsigned product for signed operands
  always_comb begin
    fix = acc_q;
    if (op_q == 2'b01 && b_q[DATA_W-1]) fix = fix - {a_q, {DATA_W{1'b0}}};
    if ((op_q[1] ^ op_q[0]) && a_q[DATA_W-1]) fix = fix - {b_q, {DATA_W{1'b0}}};
  end
  // The slice product is registered; its accumulation trails by one cycle,
  // so MAC spans N*N+1 cycles while total latency stays N*N+2 edges.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    i_d     = i_q;
    j_d     = j_q;
    sh_d    = sh_q;
    prod_d  = prod_q;
    pv_d    = 1'b0;
    last_d  = last_q;
    acc_d   = acc_q;
    prodo_d = prodo_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = in_a;
        b_d     = in_b;
        op_d    = in_op;
        acc_d   = '0;
        i_d     = '0;
        j_d     = '0;
        last_d  = 1'b0;
        state_d = MAC;
      end
      MAC: begin
        if (!last_q) begin
          prod_d = MW'(a_q[i_q*SLICE_W +: SLICE_W]) * MW'(b_q[j_q*SLICE_W +: SLICE_W]);
          pv_d   = 1'b1;
          sh_d   = {1'b0, i_q} + {1'b0, j_q};
          j_d    = j_q == LAST ? '0 : j_q + 1'b1;
          i_d    = j_q != LAST ? i_q : (i_q == LAST ? '0 : i_q + 1'b1);
          last_d = (i_q == LAST) && (j_q == LAST);
        end
        if (pv_q) acc_d = acc_q + (PW'(prod_q) << (sh_q * SLICE_W));
        if (last_q) state_d = FIX;
      end
      FIX: begin
        prodo_d = fix;
        res_d   = op_q == 2'b00 ? fix[DATA_W-1:0] : fix[PW-1:DATA_W];
        state_d = DONE;
      end
      default: if (out_ready) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      sh_q    <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      prodo_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      i_q     <= i_d;
      j_q     <= j_d;
      sh_q    <= sh_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      prodo_q <= prodo_d;
      res_q   <= res_d;
    end
  end
endmodule
